// File: rtl/image_pixel_writer.sv
// Packs the UART loader's byte stream into 24-bit RGB pixels and writes them,
// tagged with raster addresses, to pixel memory through an Avalon-MM write master.
module image_pixel_writer #(
    parameter int unsigned IMG_W      = 64,
    parameter int unsigned IMG_H      = 64,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              avm_clk,
    input  logic              avm_rst_n,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    input  logic              soft_clr,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [23:0]       pix_data,
    output logic              pix_write,
    input  logic              pix_waitrequest,
    output logic              frame_done,
    output logic              overflow
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = ADDR_W + 24;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_t;

    phase_t             phase_q, phase_d;
    logic [7:0]         r_q, g_q;
    logic [ADDR_W-1:0]  pix_cnt_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

    logic               pix_done;
    logic               fifo_empty, fifo_full;
    logic               push, pop;
    logic [ENTRY_W-1:0] head;

    // Byte phase state register
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) phase_q <= PH_R;
        else            phase_q <= phase_d;
    end

    // Byte phase next state: R -> G -> B -> R on each accepted byte
    always_comb begin
        phase_d = phase_q;
        if (soft_clr) begin
            phase_d = PH_R;
        end else if (byte_valid) begin
            unique case (phase_q)
                PH_R:    phase_d = PH_G;
                PH_G:    phase_d = PH_B;
                PH_B:    phase_d = PH_R;
                default: phase_d = PH_R;
            endcase
        end
    end

    // soft_clr wins over a same-cycle byte and a same-cycle pop
    assign pix_done   = byte_valid && !soft_clr && (phase_q == PH_B);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && !pix_waitrequest && !soft_clr;
    assign push       = pix_done && (!fifo_full || pop);
    assign head       = mem[rd_ptr_q];

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            r_q <= '0;
            g_q <= '0;
        end else if (soft_clr) begin
            r_q <= '0;
            g_q <= '0;
        end else if (byte_valid) begin
            if (phase_q == PH_R) r_q <= byte_data;
            if (phase_q == PH_G) g_q <= byte_data;
        end
    end

    // Address counter advances even for dropped pixels so later addresses stay correct
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            pix_cnt_q <= '0;
        end else if (soft_clr) begin
            pix_cnt_q <= '0;
        end else if (pix_done) begin
            pix_cnt_q <= (pix_cnt_q == LAST_ADDR) ? '0 : pix_cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge avm_clk) begin
        if (push) mem[wr_ptr_q] <= {pix_cnt_q, r_q, g_q, byte_data};
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else if (soft_clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q    <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (pix_done && !push) overflow <= 1'b1;
            frame_done <= pop && (head[ENTRY_W-1:24] == LAST_ADDR);
        end
    end

    // Master outputs decode the registered FIFO head; zero while empty
    assign pix_write = !fifo_empty;
    assign pix_addr  = fifo_empty ? '0 : head[ENTRY_W-1:24];
    assign pix_data  = fifo_empty ? '0 : head[23:0];

endmodule

// File: tb/tb_image_pixel_writer.sv
// Self-checking bench for image_pixel_writer: scoreboard of expected writes,
// a vector table of pixels, and hand-written stall/overflow/clear/reset sequences.
module tb_image_pixel_writer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        soft_clr;
    logic [11:0] pix_addr;
    logic [23:0] pix_data;
    logic        pix_write;
    logic        pix_waitrequest;
    logic        frame_done;
    logic        overflow;

    image_pixel_writer #(
        .IMG_W(64), .IMG_H(64), .ADDR_W(12), .FIFO_DEPTH(4)
    ) dut (
        .avm_clk        (clk),
        .avm_rst_n      (rst_n),
        .byte_data      (byte_data),
        .byte_valid     (byte_valid),
        .soft_clr       (soft_clr),
        .pix_addr       (pix_addr),
        .pix_data       (pix_data),
        .pix_write      (pix_write),
        .pix_waitrequest(pix_waitrequest),
        .frame_done     (frame_done),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] addr;
        logic [23:0] data;
    } exp_t;

    typedef struct {
        logic [7:0]  r, g, b;
        logic [11:0] addr;
        logic [23:0] data;
        bit          stall;
    } vec_t;

    exp_t        sb_q[$];
    int          tests  = 0;
    int          failed = 0;
    int          wr_cnt = 0;
    int          fd_cnt = 0;
    logic [11:0] tb_addr = 12'd0;
    bit          fd_exp = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Writes are accepted at the posedge following a negedge that sees write && !wait
    always @(negedge clk) begin
        bit acc_last;
        exp_t e;
        acc_last = 1'b0;
        if (frame_done || fd_exp) check("frame_done", 32'(frame_done), 32'(fd_exp));
        if (frame_done) fd_cnt++;
        if (rst_n && !soft_clr && pix_write && !pix_waitrequest) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected none", pix_addr, pix_data);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", 32'(pix_addr), 32'(e.addr));
                check("wr_data", 32'(pix_data), 32'(e.data));
            end
            acc_last = (pix_addr == 12'd4095);
        end
        fd_exp = acc_last;
    end

    task automatic send_byte(input logic [7:0] b);
        byte_data  = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic send_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input bit keep);
        exp_t e;
        e.addr = tb_addr;
        e.data = {r, g, b};
        if (keep) sb_q.push_back(e);
        tb_addr = (tb_addr == 12'd4095) ? 12'd0 : tb_addr + 12'd1;
        send_byte(r);
        send_byte(g);
        send_byte(b);
    endtask

    task automatic do_clr();
        soft_clr = 1'b1;
        @(posedge clk);
        #1;
        soft_clr = 1'b0;
        tb_addr  = 12'd0;
        sb_q.delete();
    endtask

    // Bounded wait for the scoreboard and FIFO to empty
    task automatic drain(input string nm);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !pix_write) break;
        end
        check({nm, "_q_empty"}, 32'(sb_q.size()), 32'd0);
        check({nm, "_write_low"}, 32'(pix_write), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_write"},    32'(pix_write),  32'd0);
        check({nm, "_addr"},     32'(pix_addr),   32'd0);
        check({nm, "_data"},     32'(pix_data),   32'd0);
        check({nm, "_frame"},    32'(frame_done), 32'd0);
        check({nm, "_overflow"}, 32'(overflow),   32'd0);
    endtask

    initial begin
        vec_t vt[6];
        int   k;

        vt[0] = '{r:8'hFF, g:8'h00, b:8'h80, addr:12'd1, data:24'hFF0080, stall:1'b0};
        vt[1] = '{r:8'h01, g:8'h02, b:8'h03, addr:12'd2, data:24'h010203, stall:1'b1};
        vt[2] = '{r:8'hDE, g:8'hAD, b:8'hBE, addr:12'd3, data:24'hDEADBE, stall:1'b0};
        vt[3] = '{r:8'h00, g:8'h00, b:8'h00, addr:12'd4, data:24'h000000, stall:1'b1};
        vt[4] = '{r:8'h5A, g:8'hA5, b:8'hC3, addr:12'd5, data:24'h5AA5C3, stall:1'b0};
        vt[5] = '{r:8'h7F, g:8'hFE, b:8'h10, addr:12'd6, data:24'h7FFE10, stall:1'b0};

        rst_n           = 1'b0;
        byte_data       = 8'h00;
        byte_valid      = 1'b0;
        soft_clr        = 1'b0;
        pix_waitrequest = 1'b0;
        #12;
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single pixel after reset
        send_px(8'h11, 8'h22, 8'h33, 1'b1);
        drain("single");
        check("single_wr_cnt", 32'(wr_cnt), 32'd1);
        check("single_overflow", 32'(overflow), 32'd0);

        // Vector table, some entries followed by a short stall
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            e.addr = vt[i].addr;
            e.data = vt[i].data;
            sb_q.push_back(e);
            tb_addr = tb_addr + 12'd1;
            send_byte(vt[i].r);
            send_byte(vt[i].g);
            send_byte(vt[i].b);
            if (vt[i].stall) begin
                pix_waitrequest = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                pix_waitrequest = 1'b0;
            end
        end
        drain("table");
        check("table_wr_cnt", 32'(wr_cnt), 32'd7);

        // Full frame of 4096 pixels, then wrap to address 0
        do_clr();
        fd_cnt = 0;
        for (int p = 0; p < 4096; p++) begin
            k = 3 * p;
            send_px(8'(k), 8'(k + 1), 8'(k + 2), 1'b1);
        end
        drain("frame");
        check("frame_done_cnt", 32'(fd_cnt), 32'd1);
        send_px(8'h01, 8'h02, 8'h03, 1'b1);
        drain("wrap");
        check("frame_done_cnt_after_wrap", 32'(fd_cnt), 32'd1);

        // Four pixels during a stall: head held stable, no overflow
        do_clr();
        pix_waitrequest = 1'b1;
        send_px(8'h10, 8'h20, 8'h30, 1'b1);
        send_px(8'h11, 8'h21, 8'h31, 1'b1);
        send_px(8'h12, 8'h22, 8'h32, 1'b1);
        send_px(8'h13, 8'h23, 8'h33, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_write", 32'(pix_write), 32'd1);
            check("stall_addr",  32'(pix_addr),  32'd0);
            check("stall_data",  32'(pix_data),  32'h102030);
        end
        @(posedge clk);
        #1;
        pix_waitrequest = 1'b0;
        drain("stall4");
        check("stall4_overflow", 32'(overflow), 32'd0);

        // Fifth pixel during a stall is dropped; overflow sticks
        do_clr();
        pix_waitrequest = 1'b1;
        send_px(8'hA0, 8'hB0, 8'hC0, 1'b1);
        send_px(8'hA1, 8'hB1, 8'hC1, 1'b1);
        send_px(8'hA2, 8'hB2, 8'hC2, 1'b1);
        send_px(8'hA3, 8'hB3, 8'hC3, 1'b1);
        send_px(8'hA4, 8'hB4, 8'hC4, 1'b0);
        @(negedge clk);
        check("ovf_set", 32'(overflow), 32'd1);
        @(posedge clk);
        #1;
        pix_waitrequest = 1'b0;
        drain("ovf_release");
        check("ovf_sticky", 32'(overflow), 32'd1);
        send_px(8'hA5, 8'hB5, 8'hC5, 1'b1);
        drain("ovf_next");
        check("ovf_still", 32'(overflow), 32'd1);

        // Partial pixel then soft_clr: phase, address and overflow restart
        send_byte(8'h01);
        send_byte(8'h02);
        do_clr();
        check("clr_overflow", 32'(overflow), 32'd0);
        send_px(8'hAA, 8'hBB, 8'hCC, 1'b1);
        drain("clr");
        check("clr_overflow_after", 32'(overflow), 32'd0);

        // Async reset while two entries sit in a stalled FIFO
        pix_waitrequest = 1'b1;
        send_px(8'h31, 8'h32, 8'h33, 1'b1);
        send_px(8'h41, 8'h42, 8'h43, 1'b1);
        @(negedge clk);
        check("pre_rst_write", 32'(pix_write), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        sb_q.delete();
        tb_addr = 12'd0;
        @(posedge clk);
        #1;
        rst_n           = 1'b1;
        pix_waitrequest = 1'b0;
        send_px(8'h55, 8'h66, 8'h77, 1'b1);
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/image_pixel_writer.md
# image_pixel_writer

Downstream stage of the UART image loader. Consumes the loader's byte stream (one byte per valid pulse, no backpressure) and assembles each group of 3 bytes into a 24-bit RGB pixel. Buffers pixels in a small FIFO and writes them with raster addresses to pixel memory through an Avalon-MM write master. Flags the end of every 64x64 frame and any dropped pixel.

## Interface
Parameters:
- IMG_W, 64, image width in pixels
- IMG_H, 64, image height in pixels
- ADDR_W, 12, pixel address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- FIFO_DEPTH, 4, pixel FIFO entries (power of 2, >= 2)

Ports:
- avm_clk  in  1  sole clock; all state updates on its rising edge
- avm_rst_n  in  1  asynchronous, active-low reset
- byte_data  in  8  received byte
- byte_valid  in  1  byte_data valid this cycle; single-cycle pulses, no backpressure
- soft_clr  in  1  synchronous clear of frame position, FIFO and overflow flag
- pix_addr  out  ADDR_W  write address (raster index y*IMG_W+x)
- pix_data  out  24  write data {R,G,B}
- pix_write  out  1  Avalon write request
- pix_waitrequest  in  1  slave stall; write accepted when pix_write && !pix_waitrequest
- frame_done  out  1  one-cycle pulse after last pixel of a frame is accepted
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full

## Operation
- Byte phase counter (0,1,2): phase 0 byte -> R register, phase 1 -> G, phase 2 -> B and completes a pixel; phase advances on each byte_valid, wraps 2 -> 0.
- Push-side pixel counter (ADDR_W bits) starts at 0; on each completed pixel push entry {addr=counter, data={R,G,B}}, counter increments, wrapping IMG_W*IMG_H-1 -> 0. Counter advances even if the entry is dropped, so later pixels keep correct addresses.
- FIFO entries are ADDR_W+24 bits. Push allowed when not full, or when full and a pop occurs the same cycle. Otherwise entry discarded and overflow set to 1 (cleared only by reset or soft_clr).
- Write master: pix_write = FIFO non-empty; pix_addr/pix_data = head entry; when empty, pix_addr and pix_data are 0. Pop on pix_write && !pix_waitrequest. While stalled, head addr/data stay stable.
- frame_done: registered pulse, high for exactly one cycle after the edge accepting a write whose address is IMG_W*IMG_H-1.
- soft_clr (priority over byte_valid and pop in same cycle): phase=0, R/G/B=0, pixel counter=0, FIFO emptied, overflow=0, frame_done=0; simultaneous byte discarded, in-flight write abandoned.
- Async reset mid-operation: all state to reset values immediately; partial pixel lost.

## Timing
- Reset values: pix_write=0, pix_addr=0, pix_data=0, frame_done=0, overflow=0, phase=0, pixel counter=0, FIFO empty.
- Latency: third byte sampled at edge N -> pix_write=1 with that pixel's addr/data after edge N (empty FIFO). Accepted at edge N+1 with waitrequest low.
- Sustained throughput: one write per cycle. Input max rate is one byte per cycle, i.e. one pixel per 3 cycles, so no overflow unless waitrequest stalls.
- Full + push + pop same edge: count unchanged, no overflow. Empty + push: pix_write rises next cycle; no same-cycle bypass.
- frame_done asserted the cycle after the accepting edge of the last address; never more than one pulse per frame.

## Test plan
- Reset, bytes 0x11,0x22,0x33, waitrequest=0 -> exactly one write addr=0 data=0x112233; pix_write high one cycle; overflow=0.
- Full frame of 12288 bytes (byte k = k mod 256), waitrequest=0 -> 4096 writes, addr 0..4095 in order, correct data. One frame_done pulse after addr 4095 is accepted. Next 3 bytes write addr 0.
- waitrequest=1 while 4 pixels arrive, then released -> pix_write held with stable addr 0/data during stall. Then addrs 0,1,2,3 written in order; overflow=0.
- waitrequest=1 while 5 pixels arrive -> 5th dropped, overflow=1 and stays 1. After release, writes for addrs 0-3 only. Next pixel writes addr 5.
- 2 bytes sent, then soft_clr pulse, then 0xAA,0xBB,0xCC -> single write addr=0 data=0xAABBCC; overflow cleared; FIFO empty after write.
- avm_rst_n asserted while FIFO holds 2 entries and stalled -> pix_write, pix_addr, pix_data, frame_done, overflow go 0 without a clock edge. After release, the next 3 bytes produce a write to addr 0.
